// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop.
// Operands stream LSB first and the sum is reassembled in a shift accumulator.
module adder_df (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | ((a ^ b) & cin);
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             Cout
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_next;
    logic [CW-1:0]    cnt;
    logic             carry, cell_s, cell_c, last;

    adder_df u_cell (
        .a   (op_a[0]),
        .b   (op_b[0]),
        .cin (carry),
        .s   (cell_s),
        .cout(cell_c)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == RUN);

    // Shift written as >> plus an MSB override so WIDTH=1 needs no special case.
    always_comb begin
        acc_next            = acc >> 1;
        acc_next[WIDTH-1]   = cell_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            Cout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= A;
                        op_b  <= B;
                        carry <= Cin;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= cell_c;
                    acc   <= acc_next;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum  <= acc_next;
                        Cout <= cell_c;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus a random
// scoreboard compared against plain integer addition.
module tb_serial_adder;
    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A, B;
    logic             Cin;
    logic             busy, done, Cout;
    logic [WIDTH-1:0] sum;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_done_cyc = 0;
    logic [WIDTH-1:0] exp_sum  = '0;
    logic             exp_cout = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .Cout (Cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Launches one addition and returns in the cycle where done is high
    // (or after a bounded timeout). With glitch set, start and operands are
    // disturbed from RUN cycle 3 onwards and must be ignored.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic ci, input bit glitch, input string tag);
        logic [WIDTH:0] ref_full;
        int busy_cnt;
        bit hold_ok;
        ref_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        A = a; B = b; Cin = ci; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = 0;
        hold_ok = 1'b1;
        for (int i = 0; i < 40 && done !== 1'b1; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (sum !== exp_sum || Cout !== exp_cout) hold_ok = 1'b0;
            if (glitch && i == 2) begin
                start = 1'b1; A = 8'hAA; B = 8'h55; Cin = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        check({tag, "_busy_len"}, busy_cnt, WIDTH);
        check({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        exp_sum  = ref_full[WIDTH-1:0];
        exp_cout = ref_full[WIDTH];
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_sum});
        check({tag, "_cout"}, {31'd0, Cout}, {31'd0, exp_cout});
        last_done_cyc = cyc;
    endtask

    initial begin
        int prev_done;
        int done_seen;
        rst_n = 1'b0; start = 1'b1; A = '0; B = '0; Cin = 1'b0;
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum",  {24'd0, sum},  32'd0);
        check("rst_cout", {31'd0, Cout}, 32'd0);
        rst_n = 1'b1; start = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        run_op(8'h3C, 8'h0F, 1'b0, 1'b0, "basic");
        tick();
        check("done_pulse", {31'd0, done}, 32'd0);

        run_op(8'hFF, 8'h00, 1'b1, 1'b0, "wrap1");
        tick();
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, "wrap2");
        tick();

        run_op(8'h01, 8'h02, 1'b0, 1'b1, "glitch");
        tick();
        check("glitch_no_second_busy", {31'd0, busy}, 32'd0);
        check("glitch_no_second_done", {31'd0, done}, 32'd0);

        // Back-to-back: start raised in the done cycle of the previous op.
        run_op(8'h11, 8'h22, 1'b0, 1'b0, "b2b_first");
        prev_done = last_done_cyc;
        run_op(8'h80, 8'h80, 1'b0, 1'b0, "b2b_second");
        check("b2b_period", last_done_cyc - prev_done, WIDTH + 1);
        tick();

        // Reset in RUN cycle 4 aborts the operation and clears results.
        A = 8'h77; B = 8'h66; Cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_sum",  {24'd0, sum},  32'd0);
        check("midrst_cout", {31'd0, Cout}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            tick();
        end
        check("midrst_no_done", done_seen, 0);
        exp_sum = '0; exp_cout = 1'b0;
        run_op(8'h10, 8'h20, 1'b0, 1'b0, "after_rst");
        tick();

        for (int n = 0; n < 200; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, "rand");
            if ($urandom_range(0, 1) == 0) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
